// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if
// Bundles the key-table write port, the plaintext/ciphertext valid/ready
// streams and the round-datapath issue bus of the AES round sequencer.
//
// Signals (direction as seen from the sequencer, i.e. the slave modport):
//   rk_wr_en/rk_wr_idx/rk_wr_data  in   round-key table write
//   rk_wr_err                      out  dropped-write pulse
//   keys_valid                     out  last round key has been loaded
//   in_valid/in_data               in   plaintext stream
//   in_ready                       out
//   out_valid/out_data             out  ciphertext stream
//   out_ready                      in
//   rnd_valid/rnd_data/rnd_key/rnd_last  out  round datapath issue
//   rnd_result                     in   round datapath result
//   busy                           out  block in progress
//
// master: the environment (FIFO front end, key loader, round datapath).
// slave:  the sequencer itself.
interface aes_round_sequencer_if;
  logic         rk_wr_en;
  logic [3:0]   rk_wr_idx;
  logic [127:0] rk_wr_data;
  logic         rk_wr_err;
  logic         keys_valid;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         rnd_valid;
  logic [127:0] rnd_data;
  logic [127:0] rnd_key;
  logic         rnd_last;
  logic [127:0] rnd_result;
  logic         busy;

  modport master (
    output rk_wr_en, rk_wr_idx, rk_wr_data,
    output in_valid, in_data, out_ready, rnd_result,
    input  rk_wr_err, keys_valid, in_ready, out_valid, out_data,
    input  rnd_valid, rnd_data, rnd_key, rnd_last, busy
  );

  modport slave (
    input  rk_wr_en, rk_wr_idx, rk_wr_data,
    input  in_valid, in_data, out_ready, rnd_result,
    output rk_wr_err, keys_valid, in_ready, out_valid, out_data,
    output rnd_valid, rnd_data, rnd_key, rnd_last, busy
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Iterative AES-128 encryption controller. Holds the round-key table,
// performs the initial AddRoundKey itself and then time-multiplexes one
// external round datapath over NUM_ROUNDS rounds. The datapath has a fixed
// latency of ROUND_LAT cycles and no handshake, so the sequencer simply
// counts cycles before sampling rnd_result.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    aes_round_sequencer_if.slave (key writes, in/out streams,
//          round datapath issue bus, status)
//   perf_blocks, perf_stall  out  only when AES_SEQ_PERF_EN is defined:
//          completed-block count and DONE-with-backpressure cycle count.
//
// Optional feature macro: AES_SEQ_PERF_EN
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aes_round_sequencer_if.slave   bus
`ifdef AES_SEQ_PERF_EN
  ,
  output logic [31:0]            perf_blocks,
  output logic [31:0]            perf_stall
`endif
);

  localparam int              LAT_W    = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ROUND_LAT - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_next;
  logic [3:0]       round, round_next;
  logic [LAT_W-1:0] lat_cnt, lat_next;
  logic [127:0]     st, st_next;
  logic [127:0]     out_q, out_next;
  logic             keys_valid_q;
  logic             wr_err_q;

  logic [127:0]     rk [0:NUM_ROUNDS];

  logic             wr_ok;
  logic             wr_bad;
  logic             in_ready_int;
  logic             accept;
  logic             in_round;
  logic [127:0]     rk0_eff;

  // Key writes only land while idle; anything else is reported and dropped.
  assign wr_ok  = bus.rk_wr_en && (state == IDLE) && (bus.rk_wr_idx <= LAST_IDX);
  assign wr_bad = bus.rk_wr_en && !wr_ok;

  assign in_ready_int = (state == IDLE) && keys_valid_q;
  assign accept       = bus.in_valid && in_ready_int;

  // A key-0 write in the accept cycle must already apply to this block.
  assign rk0_eff = (wr_ok && (bus.rk_wr_idx == 4'd0)) ? bus.rk_wr_data : rk[0];

  // Round-key table: plain RAM, deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      rk[bus.rk_wr_idx] <= bus.rk_wr_data;
    end
  end

  // Next-state and datapath-register logic.
  always_comb begin
    state_next = state;
    round_next = round;
    lat_next   = lat_cnt;
    st_next    = st;
    out_next   = out_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          st_next    = bus.in_data ^ rk0_eff;
          round_next = 4'd1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        lat_next   = LAT_INIT;
        state_next = WAIT;
      end
      WAIT: begin
        if (lat_cnt != '0) begin
          lat_next = lat_cnt - LAT_W'(1);
        end else begin
          st_next = bus.rnd_result;
          if (round == LAST_IDX) begin
            out_next   = bus.rnd_result;
            state_next = DONE;
          end else begin
            round_next = round + 4'd1;
            state_next = ISSUE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus key-status and error-pulse flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      round        <= '0;
      lat_cnt      <= '0;
      st           <= '0;
      out_q        <= '0;
      keys_valid_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state    <= state_next;
      round    <= round_next;
      lat_cnt  <= lat_next;
      st       <= st_next;
      out_q    <= out_next;
      wr_err_q <= wr_bad;
      if (wr_ok && (bus.rk_wr_idx == LAST_IDX)) begin
        keys_valid_q <= 1'b1;
      end
    end
  end

  // The round bus is driven only while a round is in flight, so it reads
  // zero when idle and never exposes the uninitialised key RAM.
  assign in_round = (state == ISSUE) || (state == WAIT);

  assign bus.rnd_valid  = (state == ISSUE);
  assign bus.rnd_data   = in_round ? st : '0;
  assign bus.rnd_key    = in_round ? rk[round] : '0;
  assign bus.rnd_last   = in_round && (round == LAST_IDX);

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = (state == DONE);
  assign bus.out_data   = out_q;
  assign bus.busy       = (state != IDLE);
  assign bus.keys_valid = keys_valid_q;
  assign bus.rk_wr_err  = wr_err_q;

`ifdef AES_SEQ_PERF_EN
  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_blocks <= '0;
      perf_stall  <= '0;
    end else if (state == DONE) begin
      if (bus.out_ready) begin
        perf_blocks <= perf_blocks + 32'd1;
      end else begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller: time-multiplexes one external round datapath (SubBytes/ShiftRows/MixColumns + AddRoundKey) over all NUM_ROUNDS rounds of a block.
- Holds the 11-entry round-key table and applies the initial AddRoundKey internally.
- Sits between the cohort accelerator FIFO front end (valid/ready) and the round datapath.
- Counts the round datapath's fixed pipeline latency. The round datapath gives no handshake back.

Parameters:
- NUM_ROUNDS, 10, rounds per block. The final round is flagged via rnd_last.
- ROUND_LAT, 2, fixed clock latency of the round datapath from rnd_data/rnd_key to rnd_result. Must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rk_wr_en  in  1  round-key table write strobe.
- rk_wr_idx  in  4  round-key index 0..NUM_ROUNDS.
- rk_wr_data  in  128  round-key value.
- rk_wr_err  out  1  one-cycle pulse: write dropped (busy or idx>NUM_ROUNDS).
- keys_valid  out  1  set once index NUM_ROUNDS has been written.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  = (state==IDLE) & keys_valid.
- in_data  in  128  plaintext.
- out_valid  out  1  ciphertext valid, held until accepted.
- out_ready  in  1  consumer ready.
- out_data  out  128  ciphertext.
- rnd_valid  out  1  one-cycle issue strobe to the round datapath (debug/gating only).
- rnd_data  out  128  round input state.
- rnd_key  out  128  round key for this round.
- rnd_last  out  1  high during the issue of round NUM_ROUNDS: datapath bypasses MixColumns.
- rnd_result  in  128  round datapath output, sampled ROUND_LAT cycles after issue.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, round=0, lat_cnt=0, keys_valid=0.
  - All outputs 0, including out_data, rnd_data and rnd_key.
  - Key RAM contents need not be cleared.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On in_valid & in_ready: st <= in_data ^ rk[0], round <= 1, go ISSUE.
- ISSUE (1 cycle):
  - rnd_valid=1, rnd_data=st, rnd_key=rk[round], rnd_last=(round==NUM_ROUNDS).
  - lat_cnt <= ROUND_LAT-1, go WAIT.
  - rnd_data, rnd_key and rnd_last stay stable through WAIT. rnd_valid is 0 in WAIT.
- WAIT:
  - If lat_cnt != 0: decrement.
  - If lat_cnt == 0: st <= rnd_result.
    - If round==NUM_ROUNDS: go DONE.
    - Otherwise: round++, go ISSUE.
- DONE:
  - out_valid=1, out_data=st.
  - On out_ready: go IDLE, out_valid drops next cycle.
  - out_data holds its value after leaving DONE until the next DONE.
- Latency:
  - The handshake edge is cycle 0. out_valid is first high in cycle 1+NUM_ROUNDS*(1+ROUND_LAT), which is 31 for the defaults.
  - Next in_ready comes one cycle after the out handshake. No overlap between blocks.
- Key writes:
  - Accepted only in IDLE with rk_wr_idx ≤ NUM_ROUNDS.
  - Otherwise the write is dropped and rk_wr_err pulses for one cycle.
  - Writing idx NUM_ROUNDS sets keys_valid, which stays set until reset.
  - A key write and an in handshake in the same IDLE cycle: the key write takes effect first. The block uses the new rk[0] for the initial AddRoundKey (write-through bypass).
- in_valid while not ready: ignored. in_data is not captured.
- Reset mid-block: immediate return to IDLE. The in-flight block is discarded and keys_valid clears, so keys must be reloaded.

Optional Feature:
- Macro AES_SEQ_PERF_EN.
- When defined, add two outputs:
  - perf_blocks[31:0]: increments on each out handshake.
  - perf_stall[31:0]: increments every cycle in DONE with out_ready=0.
- Both counters wrap at 2^32 and clear on reset.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- FIPS-197 C.1 vector: load the 11 round keys expanded from key 000102030405060708090a0b0c0d0e0f, send 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid first high exactly 31 cycles after the handshake. rnd_last is high only in round 10's issue cycle.
- Back-pressure: out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable, in_ready=0. out_ready=1 -> in_ready=1 on the following cycle.
- Key-write protection: rk_wr_en with idx 3 while busy -> rk_wr_err pulse and ciphertext unchanged. Write with idx 12 in IDLE -> rk_wr_err pulse. Before idx 10 is written, in_ready=0.
- Reset mid-operation: assert rst_n=0 during round 5 WAIT -> all outputs 0 asynchronously, keys_valid=0. After reloading keys the C.1 vector still gives the correct ciphertext.
- Same-cycle key write and accept: write rk[0] and hand over plaintext in one cycle -> the result matches the new key schedule.
- With AES_SEQ_PERF_EN: 3 back-to-back blocks, 5 stall cycles on the second -> perf_blocks=3, perf_stall=5.
